// File: rtl/edge_pkg.sv
// Shared types and sizes for the edge-detection pipeline stages.
package edge_pkg;
    localparam int BLUR_W = 16;
    localparam int GRAD_W = BLUR_W - 2;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} grad_state_t;
endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: magnitude (|Gx|+|Gy|)>>3 and a 4-way direction.
module sobel_kernel
    import edge_pkg::*;
(
    input  logic [71:0] win_i,   // row-major: top l,c,r / mid l,c,r / bot l,c,r
    output pixel_t      mag_o,
    output dir_t        dir_o
);
    pixel_t             px [9];
    logic [9:0]         sx_r, sx_l, sy_b, sy_t;
    logic signed [11:0] gx, gy;
    logic [10:0]        ax, ay, sum;
    logic [12:0]        ax2, ay2, ax5, ay5;
    logic               centre_unused;

    for (genvar gi = 0; gi < 9; gi++) begin : g_px
        assign px[gi] = win_i[gi*8 +: 8];
    end

    // The centre pixel contributes to neither kernel.
    assign centre_unused = ^px[4];

    always_comb begin
        sx_r = {2'b00, px[2]} + {1'b0, px[5], 1'b0} + {2'b00, px[8]};
        sx_l = {2'b00, px[0]} + {1'b0, px[3], 1'b0} + {2'b00, px[6]};
        sy_b = {2'b00, px[6]} + {1'b0, px[7], 1'b0} + {2'b00, px[8]};
        sy_t = {2'b00, px[0]} + {1'b0, px[1], 1'b0} + {2'b00, px[2]};
        gx   = $signed({2'b00, sx_r}) - $signed({2'b00, sx_l});
        gy   = $signed({2'b00, sy_b}) - $signed({2'b00, sy_t});
        ax   = gx[11] ? 11'(-gx) : 11'(gx);
        ay   = gy[11] ? 11'(-gy) : 11'(gy);
        sum  = ax + ay;
        ax2  = {1'b0, ax, 1'b0};
        ay2  = {1'b0, ay, 1'b0};
        ax5  = {ax, 2'b00} + {2'b00, ax};
        ay5  = {ay, 2'b00} + {2'b00, ay};
        mag_o = 8'(sum >> 3);
        // tan(22.5deg) ~ 2/5; a zero gradient component counts as positive.
        if (ay5 <= ax2)
            dir_o = DIR_0;
        else if (ax5 <= ay2)
            dir_o = DIR_90;
        else if (gx[11] == gy[11])
            dir_o = DIR_45;
        else
            dir_o = DIR_135;
    end
endmodule

// File: rtl/gradient_controller.sv
// Sobel gradient stage: buffers three blurred rows, computes one output column
// per cycle through a shared kernel, then strobes grad_final.
module gradient_controller
    import edge_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  blur_final,
    input  logic [31:0]           anchor_y,
    input  logic [BLUR_W*8-1:0]   blur_out,
    output logic [GRAD_W*8-1:0]   grad_mag,
    output logic [GRAD_W*2-1:0]   grad_dir,
    output logic                  grad_valid,
    output logic                  grad_final,
    output logic                  grad_overrun
);
    logic [BLUR_W*8-1:0] top_q, mid_q, bot_q;
    logic [1:0]          rows_q, rows_d;
    logic [3:0]          col_q;
    grad_state_t         state_q;
    pixel_t              mag_q [GRAD_W];
    dir_t                dir_q [GRAD_W];
    logic [71:0]         win;
    pixel_t              k_mag;
    dir_t                k_dir;

    // A frame start restarts the count so its first two rows are flagged invalid.
    always_comb begin
        rows_d = rows_q + 2'd1;
        if (anchor_y == 32'd0)
            rows_d = 2'd1;
        else if (rows_q == 2'd3)
            rows_d = 2'd3;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_win
        assign win[gi*8 +: 8]     = top_q[(int'(col_q) + gi)*8 +: 8];
        assign win[(gi+3)*8 +: 8] = mid_q[(int'(col_q) + gi)*8 +: 8];
        assign win[(gi+6)*8 +: 8] = bot_q[(int'(col_q) + gi)*8 +: 8];
    end

    sobel_kernel u_kernel (
        .win_i (win),
        .mag_o (k_mag),
        .dir_o (k_dir)
    );

    for (genvar gi = 0; gi < GRAD_W; gi++) begin : g_out
        assign grad_mag[gi*8 +: 8] = mag_q[gi];
        assign grad_dir[gi*2 +: 2] = dir_q[gi];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            rows_q       <= 2'd0;
            col_q        <= 4'd0;
            grad_valid   <= 1'b0;
            grad_final   <= 1'b0;
            grad_overrun <= 1'b0;
            for (int i = 0; i < GRAD_W; i++) begin
                mag_q[i] <= '0;
                dir_q[i] <= DIR_0;
            end
        end else begin
            grad_final <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (blur_final) begin
                        top_q   <= mid_q;
                        mid_q   <= bot_q;
                        bot_q   <= blur_out;
                        rows_q  <= rows_d;
                        col_q   <= 4'd0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (blur_final)
                        grad_overrun <= 1'b1;
                    mag_q[col_q] <= k_mag;
                    dir_q[col_q] <= k_dir;
                    col_q        <= col_q + 4'd1;
                    if (col_q == 4'(GRAD_W - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (blur_final)
                        grad_overrun <= 1'b1;
                    grad_final <= 1'b1;
                    grad_valid <= (rows_q == 2'd3);
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
